// File: rtl/vga_pkg.sv
// Shared 640x480@60 VGA timing constants and helpers for deriving
// totals and sync pulse bounds from the porch/visible parameters.
package vga_pkg;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  function automatic int line_total(int visible, int front, int sync, int back);
    return visible + front + sync + back;
  endfunction

  // Sync pulse is the half-open interval [pulse_start, pulse_end).
  function automatic int pulse_start(int visible, int front);
    return visible + front;
  endfunction

  function automatic int pulse_end(int visible, int front, int sync);
    return visible + front + sync;
  endfunction

  localparam int DEF_H_TOTAL      = line_total(DEF_H_VISIBLE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
  localparam int DEF_V_TOTAL      = line_total(DEF_V_VISIBLE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);
  localparam int DEF_H_SYNC_START = pulse_start(DEF_H_VISIBLE, DEF_H_FRONT);
  localparam int DEF_H_SYNC_END   = pulse_end(DEF_H_VISIBLE, DEF_H_FRONT, DEF_H_SYNC);
  localparam int DEF_V_SYNC_START = pulse_start(DEF_V_VISIBLE, DEF_V_FRONT);
  localparam int DEF_V_SYNC_END   = pulse_end(DEF_V_VISIBLE, DEF_V_FRONT, DEF_V_SYNC);

  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic [2:0] rgb;
  } sync_stage_t;

  localparam sync_stage_t STAGE_IDLE = '{hsync: 1'b1, vsync: 1'b1, rgb: 3'b000};

endpackage

// File: rtl/vga_sync_gen.sv
// VGA raster counters with a one-pixel registered stage producing
// active-low hsync/vsync and blanked colour for the DAC.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_ce,
  input  logic [2:0] rgb_in,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       frame_start,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] rgb
);

  localparam int H_TOTAL = line_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = line_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(pulse_start(H_VISIBLE, H_FRONT));
  localparam logic [9:0] HS_END   = 10'(pulse_end(H_VISIBLE, H_FRONT, H_SYNC));
  localparam logic [9:0] VS_START = 10'(pulse_start(V_VISIBLE, V_FRONT));
  localparam logic [9:0] VS_END   = 10'(pulse_end(V_VISIBLE, V_FRONT, V_SYNC));

  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  sync_stage_t stage_q;
  sync_stage_t stage_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_ce) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  assign video_on = (h_cnt < H_VIS) && (v_cnt < V_VIS);

  // NOTE: every field gets a default before any conditional logic so this
  // block can never infer a latch.
  always_comb begin
    stage_d       = STAGE_IDLE;
    stage_d.hsync = !((h_cnt >= HS_START) && (h_cnt < HS_END));
    stage_d.vsync = !((v_cnt >= VS_START) && (v_cnt < VS_END));
    stage_d.rgb   = video_on ? rgb_in : 3'b000;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_q <= STAGE_IDLE;
    end else if (pix_ce) begin
      stage_q <= stage_d;
    end
  end

  // Gated by reset so the pulse is suppressed while the counters are forced to 0/0.
  assign frame_start = reset && pix_ce && (h_cnt == '0) && (v_cnt == '0);

  assign pixel_x = h_cnt;
  assign pixel_y = v_cnt;
  assign hsync   = stage_q.hsync;
  assign vsync   = stage_q.vsync;
  assign rgb     = stage_q.rgb;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench: a 640x480 instance and a shrunken-timing instance
// share stimulus and are compared against a pixel-index raster model.
module tb_vga_sync_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pix_ce = 1'b0;
  logic [2:0] rgb_in = 3'b000;

  logic [9:0] a_x, a_y, b_x, b_y;
  logic       a_vo, a_fs, a_hs, a_vs, b_vo, b_fs, b_hs, b_vs;
  logic [2:0] a_rgb, b_rgb;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: number of accepted pixel periods since reset release.
  int         p = 0;
  bit         have_prev = 1'b0;
  int         prev_p = 0;
  logic [2:0] prev_rgb = 3'b000;

  bit measure = 1'b0;
  int hs_low_cnt = 0;
  int hs_first_low = -1;

  vga_sync_gen dut_a (
    .clk(clk), .reset(reset), .pix_ce(pix_ce), .rgb_in(rgb_in),
    .pixel_x(a_x), .pixel_y(a_y), .video_on(a_vo), .frame_start(a_fs),
    .hsync(a_hs), .vsync(a_vs), .rgb(a_rgb)
  );

  vga_sync_gen #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(4),
    .V_VISIBLE(8),  .V_FRONT(1), .V_SYNC(2), .V_BACK(3)
  ) dut_b (
    .clk(clk), .reset(reset), .pix_ce(pix_ce), .rgb_in(rgb_in),
    .pixel_x(b_x), .pixel_y(b_y), .video_on(b_vo), .frame_start(b_fs),
    .hsync(b_hs), .vsync(b_vs), .rgb(b_rgb)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h (pixel index %0d)", tag, obs, exp, p);
  endtask

  task automatic check_inst(
    input string name,
    input int hv, input int hf, input int hsw, input int hb,
    input int vv, input int vf, input int vsw, input int vb,
    input logic [9:0] px, input logic [9:0] py, input logic vo, input logic fs,
    input logic hs, input logic vs, input logic [2:0] c
  );
    int ht, vt, x, y, qx, qy;
    logic e_hs, e_vs, e_fs;
    logic [2:0] e_rgb;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    x  = p % ht;
    y  = (p / ht) % vt;
    e_fs = reset && pix_ce && (x == 0) && (y == 0);
    if (have_prev) begin
      qx    = prev_p % ht;
      qy    = (prev_p / ht) % vt;
      e_hs  = !(qx >= hv + hf && qx < hv + hf + hsw);
      e_vs  = !(qy >= vv + vf && qy < vv + vf + vsw);
      e_rgb = (qx < hv && qy < vv) ? prev_rgb : 3'b000;
    end else begin
      e_hs  = 1'b1;
      e_vs  = 1'b1;
      e_rgb = 3'b000;
    end
    check({name, ".pixel_x"},     px, 10'(x));
    check({name, ".pixel_y"},     py, 10'(y));
    check({name, ".video_on"},    10'(vo), 10'(x < hv && y < vv));
    check({name, ".frame_start"}, 10'(fs), 10'(e_fs));
    check({name, ".hsync"},       10'(hs), 10'(e_hs));
    check({name, ".vsync"},       10'(vs), 10'(e_vs));
    check({name, ".rgb"},         10'(c),  10'(e_rgb));
  endtask

  task automatic check_all();
    check_inst("full", 640, 16, 96, 48, 480, 10, 2, 33,
               a_x, a_y, a_vo, a_fs, a_hs, a_vs, a_rgb);
    check_inst("small", 16, 2, 3, 4, 8, 1, 2, 3,
               b_x, b_y, b_vo, b_fs, b_hs, b_vs, b_rgb);
  endtask

  // One clk: drive at the falling edge, check mid-cycle, advance model on the rising edge.
  task automatic step(input logic ce, input logic [2:0] c);
    pix_ce = ce;
    rgb_in = c;
    #1;
    check_all();
    if (measure && ce && p >= 1 && p <= 800 && !a_hs) begin
      hs_low_cnt++;
      if (hs_first_low < 0) hs_first_low = p;
    end
    @(posedge clk);
    if (reset && ce) begin
      prev_p    = p;
      prev_rgb  = c;
      have_prev = 1'b1;
      p++;
    end
    @(negedge clk);
  endtask

  initial begin
    // Reset asserted from time zero; outputs must already be idle.
    @(negedge clk);
    #1;
    check_all();
    step(1'b1, 3'b101);
    step(1'b0, 3'b000);
    reset = 1'b1;

    // Pixel enable on every second clk for two full lines of the 640x480 raster.
    step(1'b0, 3'($urandom));
    measure = 1'b1;
    for (int i = 0; i < 3300; i++) step(i % 2 == 0, 3'($urandom));
    measure = 1'b0;
    check("full.hsync_low_periods", 10'(hs_low_cnt), 10'd96);
    check("full.hsync_first_low",   10'(hs_first_low), 10'd657);

    // Irregular enable; white input then random colours.
    for (int i = 0; i < 1000; i++) step($urandom_range(0, 3) != 0, 3'b111);
    for (int i = 0; i < 1000; i++) step($urandom_range(0, 3) != 0, 3'($urandom));

    // Continuous enable up to the last pixel of the small frame, then stall there.
    for (int i = 0; i < 400 && (p % 350) != 349; i++) step(1'b1, 3'($urandom));
    check("small.at_frame_end", 10'(p % 350), 10'd349);
    step(1'b1, 3'b110);
    for (int i = 0; i < 10; i++) step(1'b0, 3'($urandom));
    step(1'b1, 3'b011);
    for (int i = 0; i < 700; i++) step(1'b1, 3'($urandom));

    // Mid-frame asynchronous reset: outputs must drop without a clock edge.
    for (int i = 0; i < 37; i++) step(i % 2 == 0, 3'($urandom));
    pix_ce = 1'b1;
    reset  = 1'b0;
    p         = 0;
    have_prev = 1'b0;
    #1;
    check_all();
    for (int i = 0; i < 4; i++) step(1'b1, 3'($urandom));
    reset = 1'b1;
    for (int i = 0; i < 900; i++) step($urandom_range(0, 1) == 1, 3'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter H_VISIBLE, default 640, active pixels per line.
REQ-002 Parameter H_FRONT, default 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 96, hsync pulse width in pixels.
REQ-004 Parameter H_BACK, default 48, horizontal back porch in pixels; line total H_TOTAL = sum = 800.
REQ-005 Parameters V_VISIBLE 480, V_FRONT 10, V_SYNC 2, V_BACK 33, all in lines; frame total V_TOTAL = 525.
REQ-006 clk  input  1  system clock, 50 MHz; the block's only clock.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 pix_ce  input  1  pixel clock enable, one clk wide; nominally every second clk (25 MHz pixel rate).
REQ-009 rgb_in  input  3  pixel colour for the current pixel_x/pixel_y, from the pixel generator, valid in the same clk as pix_ce.
REQ-010 pixel_x  output  10  current horizontal counter, 0..H_TOTAL-1.
REQ-011 pixel_y  output  10  current vertical counter, 0..V_TOTAL-1.
REQ-012 video_on  output  1  high when pixel_x < H_VISIBLE and pixel_y < V_VISIBLE (combinational from the counters).
REQ-013 frame_start  output  1  one-clk pulse at the start of each frame.
REQ-014 hsync, vsync  output  1 each  active-low sync pulses, registered.
REQ-015 rgb  output  3  blanked, registered colour to the DAC pins.

Function
REQ-016 h_cnt SHALL advance only on clk edges with pix_ce=1 and SHALL hold otherwise.
REQ-017 h_cnt SHALL wrap from H_TOTAL-1 to 0; on that same edge v_cnt SHALL increment.
REQ-018 v_cnt SHALL wrap from V_TOTAL-1 to 0 only when h_cnt also wraps (simultaneous wrap at 799/524 gives 0/0).
REQ-019 pixel_x/pixel_y SHALL equal h_cnt/v_cnt directly, with no added delay.
REQ-020 Stage-1 register, loaded only on pix_ce=1: rgb <= video_on ? rgb_in : 3'b000.
REQ-021 In the same stage-1 register, hsync SHALL be 0 iff H_VISIBLE+H_FRONT <= h_cnt < H_VISIBLE+H_FRONT+H_SYNC (656..751).
REQ-022 In the same stage-1 register, vsync SHALL be 0 iff V_VISIBLE+V_FRONT <= v_cnt < V_VISIBLE+V_FRONT+V_SYNC (490..491).
REQ-023 rgb, hsync and vsync SHALL therefore lag pixel_x/pixel_y by exactly one pix_ce period, mutually aligned.
REQ-024 frame_start SHALL be 1 for exactly the clk where pix_ce=1, h_cnt=0 and v_cnt=0, and 0 otherwise.
REQ-025 If pix_ce is held high continuously, the counters SHALL advance every clk with no skipped or repeated counts.
REQ-026 rgb SHALL be 000 whenever the stage-1 sample was outside the visible area, regardless of rgb_in.

Reset
REQ-027 While reset=0: h_cnt=0, v_cnt=0, hsync=1, vsync=1, rgb=000, and frame_start=0, asynchronously.
REQ-028 After reset release mid-frame, counting SHALL restart at 0/0, and the first pix_ce SHALL produce frame_start=1.

Structure
REQ-029 The 640x480@60 timing constants and the derived H_TOTAL/V_TOTAL and sync start/end values SHALL live in the shared package vga_pkg.
REQ-030 The block SHALL be flat with no sub-module; it replaces the internal counters of the existing VGA logic stage and feeds the top level.

Verification
REQ-031 Reset low then release, pix_ce toggling every clk -> hsync=vsync=1 and rgb=000 before the first pix_ce; frame_start=1 on the first pix_ce.
REQ-032 Run one full line -> hsync low for exactly 96 pix_ce periods, first low on the pix_ce after h_cnt=656; line period = 800 pix_ce periods = 1600 clk.
REQ-033 Run one full frame -> vsync low for 2 lines (v_cnt 490-491, shifted by one pixel); frame_start period = 420000 pix_ce periods.
REQ-034 rgb_in=3'b111 held constant -> rgb=111 for 640 pixels per visible line and 000 during h_cnt 640..799 and v_cnt 480..524.
REQ-035 pix_ce held low for 10 clk at h_cnt=799, v_cnt=524 -> all outputs hold; the next pix_ce wraps to 0/0 and pulses frame_start.
REQ-036 Assert reset at h_cnt=300, v_cnt=200 -> outputs go to reset values in the same clk without a clock edge; counting resumes from 0/0 after release.
